// File: rtl/nrd_seq_divider_ctrl.sv
// Sequential non-restoring divider: one add/subtract step per clock on a shared adder.
// Optional macro NRD_DIV_ZERO_EN: short-circuit Y=0 straight to FIX and raise div_zero.
module nrd_seq_divider_ctrl #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] X,
  input  logic [WIDTH-1:0] Y,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] Q,
  output logic [WIDTH:0]   R,
  output logic             div_zero
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_INIT = CW'(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_STEP = 2'd1,
    S_FIX  = 2'd2
  } state_t;

  state_t state_r, state_nxt_s;

  logic [WIDTH:0]   a_r, a_nxt_s;
  logic [WIDTH:0]   d_r, d_nxt_s;
  logic [WIDTH-1:0] qr_r, qr_nxt_s;
  logic [CW-1:0]    count_r, count_nxt_s;
  logic             dz_pend_r, dz_pend_nxt_s;
  logic             busy_r, busy_nxt_s;
  logic             done_r, done_nxt_s;
  logic             dz_r, dz_nxt_s;
  logic [WIDTH-1:0] q_r, q_nxt_s;
  logic [WIDTH:0]   r_r, r_nxt_s;

  logic             y_zero_s;
  logic [WIDTH:0]   shift_a_s;
  logic             sub_s;
  logic [WIDTH:0]   add_a_s;
  logic [WIDTH:0]   add_b_s;
  logic [WIDTH:0]   sum_s;

`ifdef NRD_DIV_ZERO_EN
  assign y_zero_s = (Y == {WIDTH{1'b0}});
`else
  assign y_zero_s = 1'b0;
`endif

  // Shared adder: STEP adds/subtracts D to the shifted A, FIX adds D back to A for the restore
  assign shift_a_s = {a_r[WIDTH-1:0], qr_r[WIDTH-1]};
  assign sub_s     = (state_r == S_STEP) && !a_r[WIDTH];
  assign add_a_s   = (state_r == S_FIX) ? a_r : shift_a_s;
  assign add_b_s   = sub_s ? ~d_r : d_r;
  assign sum_s     = add_a_s + add_b_s + {{WIDTH{1'b0}}, sub_s};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= S_IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt_s = state_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          state_nxt_s = y_zero_s ? S_FIX : S_STEP;
        end else begin
          state_nxt_s = S_IDLE;
        end
      end
      S_STEP: begin
        if (count_r == CNT_ONE) begin
          state_nxt_s = S_FIX;
        end else begin
          state_nxt_s = S_STEP;
        end
      end
      S_FIX:   state_nxt_s = S_IDLE;
      default: state_nxt_s = S_IDLE;
    endcase
  end

  // Datapath and output next values
  always_comb begin
    a_nxt_s       = a_r;
    d_nxt_s       = d_r;
    qr_nxt_s      = qr_r;
    count_nxt_s   = count_r;
    dz_pend_nxt_s = dz_pend_r;
    busy_nxt_s    = busy_r;
    done_nxt_s    = 1'b0;
    dz_nxt_s      = dz_r;
    q_nxt_s       = q_r;
    r_nxt_s       = r_r;
    case (state_r)
      S_IDLE: begin
        if (start) begin
          a_nxt_s       = {(WIDTH+1){1'b0}};
          qr_nxt_s      = X;
          d_nxt_s       = {1'b0, Y};
          count_nxt_s   = CNT_INIT;
          busy_nxt_s    = 1'b1;
          dz_nxt_s      = 1'b0;
          dz_pend_nxt_s = y_zero_s;
        end else begin
          busy_nxt_s    = 1'b0;
        end
      end
      S_STEP: begin
        a_nxt_s     = sum_s;
        qr_nxt_s    = {qr_r[WIDTH-2:0], ~sum_s[WIDTH]};
        count_nxt_s = count_r - CNT_ONE;
      end
      S_FIX: begin
        if (dz_pend_r) begin
          // Qr still holds the captured dividend on the short-circuit path
          q_nxt_s  = {WIDTH{1'b1}};
          r_nxt_s  = {1'b0, qr_r};
          dz_nxt_s = 1'b1;
        end else begin
          q_nxt_s  = qr_r;
          r_nxt_s  = a_r[WIDTH] ? sum_s : a_r;
        end
        done_nxt_s    = 1'b1;
        busy_nxt_s    = 1'b0;
        dz_pend_nxt_s = 1'b0;
      end
      default: begin
        busy_nxt_s = 1'b0;
      end
    endcase
  end

  // Datapath and output registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_r       <= {(WIDTH+1){1'b0}};
      d_r       <= {(WIDTH+1){1'b0}};
      qr_r      <= {WIDTH{1'b0}};
      count_r   <= {CW{1'b0}};
      dz_pend_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      dz_r      <= 1'b0;
      q_r       <= {WIDTH{1'b0}};
      r_r       <= {(WIDTH+1){1'b0}};
    end else begin
      a_r       <= a_nxt_s;
      d_r       <= d_nxt_s;
      qr_r      <= qr_nxt_s;
      count_r   <= count_nxt_s;
      dz_pend_r <= dz_pend_nxt_s;
      busy_r    <= busy_nxt_s;
      done_r    <= done_nxt_s;
      dz_r      <= dz_nxt_s;
      q_r       <= q_nxt_s;
      r_r       <= r_nxt_s;
    end
  end

  assign busy     = busy_r;
  assign done     = done_r;
  assign Q        = q_r;
  assign R        = r_r;
  assign div_zero = dz_r;

endmodule

// File: tb/tb_nrd_seq_divider_ctrl.sv
// Self-checking bench for nrd_seq_divider_ctrl (WIDTH=4) against an integer divide/modulo model.
module tb_nrd_seq_divider_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic [3:0] X = 4'd0;
  logic [3:0] Y = 4'd0;
  logic       busy;
  logic       done;
  logic [3:0] Q;
  logic [4:0] R;
  logic       div_zero;

  int errors = 0;
  int checks = 0;

`ifdef NRD_DIV_ZERO_EN
  localparam bit DZ_EN = 1'b1;
`else
  localparam bit DZ_EN = 1'b0;
`endif

  nrd_seq_divider_ctrl #(.WIDTH(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .X(X), .Y(Y),
    .busy(busy), .done(done), .Q(Q), .R(R), .div_zero(div_zero)
  );

  always #5 clk = ~clk;

  function automatic logic [3:0] ref_q(input logic [3:0] x, input logic [3:0] y);
    if (y == 4'd0) return 4'hF;
    return x / y;
  endfunction

  function automatic logic [4:0] ref_r(input logic [3:0] x, input logic [3:0] y);
    if (y == 4'd0) return {1'b0, x};
    return {1'b0, x % y};
  endfunction

  function automatic int ref_lat(input logic [3:0] y);
    return (DZ_EN && y == 4'd0) ? 1 : 5;
  endfunction

  function automatic logic ref_dz(input logic [3:0] y);
    return DZ_EN && (y == 4'd0);
  endfunction

  // Issue one division and wait (bounded) for done; lat=-1 means timeout
  task automatic do_op(input logic [3:0] x, input logic [3:0] y, output int lat,
                       output int busy_cyc, output logic [3:0] q, output logic [4:0] r,
                       output logic dz);
    @(negedge clk);
    X = x; Y = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; X = 4'($urandom); Y = 4'($urandom);
    busy_cyc = busy ? 1 : 0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (busy) busy_cyc++;
      if (done) begin lat = i; break; end
    end
    q = Q; r = R; dz = div_zero;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    #12;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done got=%b exp=0", done); end
    checks++; if (Q !== 4'd0) begin errors++; $display("FAIL reset_q got=%0d exp=0", Q); end
    checks++; if (R !== 5'd0) begin errors++; $display("FAIL reset_r got=%0d exp=0", R); end
    checks++; if (div_zero !== 1'b0) begin errors++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_basic;
    int lat, bc; logic [3:0] q; logic [4:0] r; logic dz;
    do_op(4'd13, 4'd3, lat, bc, q, r, dz);
    checks++; if (lat !== 5) begin errors++; $display("FAIL basic_latency got=%0d exp=5", lat); end
    checks++; if (bc !== 5) begin errors++; $display("FAIL basic_busy_cycles got=%0d exp=5", bc); end
    checks++; if (q !== 4'd4) begin errors++; $display("FAIL basic_q got=%0d exp=4", q); end
    checks++; if (r !== 5'd1) begin errors++; $display("FAIL basic_r got=%0d exp=1", r); end
    @(posedge clk); #1;
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL basic_done_single got=%b exp=0", done); end
    checks++; if (Q !== 4'd4 || R !== 5'd1) begin errors++; $display("FAIL basic_hold got=%0d/%0d exp=4/1", Q, R); end
  endtask

  task automatic test_vectors;
    logic [3:0] xs [0:2] = '{4'd7, 4'd15, 4'd0};
    logic [3:0] ys [0:2] = '{4'd9, 4'd1, 4'd5};
    int lat, bc; logic [3:0] q, x, y; logic [4:0] r; logic dz;
    for (int i = 0; i < 28; i++) begin
      if (i < 3) begin x = xs[i]; y = ys[i]; end
      else begin x = 4'($urandom); y = 4'($urandom); end
      do_op(x, y, lat, bc, q, r, dz);
      checks++; if (lat !== ref_lat(y)) begin errors++; $display("FAIL vec_latency x=%0d y=%0d got=%0d exp=%0d", x, y, lat, ref_lat(y)); end
      checks++; if (q !== ref_q(x, y)) begin errors++; $display("FAIL vec_q x=%0d y=%0d got=%0d exp=%0d", x, y, q, ref_q(x, y)); end
      checks++; if (r !== ref_r(x, y)) begin errors++; $display("FAIL vec_r x=%0d y=%0d got=%0d exp=%0d", x, y, r, ref_r(x, y)); end
      checks++; if (dz !== ref_dz(y)) begin errors++; $display("FAIL vec_dz x=%0d y=%0d got=%b exp=%b", x, y, dz, ref_dz(y)); end
    end
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic [3:0] q; logic [4:0] r; logic dz;
    do_op(4'd13, 4'd3, lat, bc, q, r, dz);
    checks++; if (q !== 4'd4 || r !== 5'd1) begin errors++; $display("FAIL b2b_first got=%0d/%0d exp=4/1", q, r); end
    X = 4'd12; Y = 4'd4; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      if (done) begin lat = i; break; end
      checks++; if (Q !== 4'd4 || R !== 5'd1) begin errors++; $display("FAIL b2b_hold cyc=%0d got=%0d/%0d exp=4/1", i, Q, R); end
    end
    checks++; if (lat !== 5) begin errors++; $display("FAIL b2b_latency got=%0d exp=5", lat); end
    checks++; if (Q !== 4'd3 || R !== 5'd0) begin errors++; $display("FAIL b2b_second got=%0d/%0d exp=3/0", Q, R); end
  endtask

  task automatic test_ignore_start;
    int lat;
    @(negedge clk);
    X = 4'd13; Y = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    lat = -1;
    for (int i = 1; i <= 20; i++) begin
      @(posedge clk); #1;
      start = (i == 1);
      if (i == 1) begin X = 4'd1; Y = 4'd1; end
      if (done) begin lat = i; break; end
    end
    start = 1'b0;
    checks++; if (lat !== 5) begin errors++; $display("FAIL ignore_latency got=%0d exp=5", lat); end
    checks++; if (Q !== 4'd4 || R !== 5'd1) begin errors++; $display("FAIL ignore_result got=%0d/%0d exp=4/1", Q, R); end
    @(posedge clk); #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL ignore_no_restart busy=%b done=%b exp=0/0", busy, done); end
  endtask

  task automatic test_reset_mid;
    int lat, bc, seen; logic [3:0] q; logic [4:0] r; logic dz;
    @(negedge clk);
    X = 4'd13; Y = 4'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    #1;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL midrst_ctrl busy=%b done=%b exp=0/0", busy, done); end
    checks++; if (Q !== 4'd0 || R !== 5'd0) begin errors++; $display("FAIL midrst_qr got=%0d/%0d exp=0/0", Q, R); end
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    repeat (7) begin @(posedge clk); #1; if (done || busy) seen++; end
    checks++; if (seen !== 0) begin errors++; $display("FAIL midrst_no_done got=%0d exp=0", seen); end
    do_op(4'd15, 4'd4, lat, bc, q, r, dz);
    checks++; if (lat !== 5 || q !== 4'd3 || r !== 5'd3) begin errors++; $display("FAIL midrst_restart lat=%0d q=%0d r=%0d exp=5/3/3", lat, q, r); end
  endtask

  task automatic test_div_zero;
    int lat, bc; logic [3:0] q; logic [4:0] r; logic dz;
    do_op(4'd9, 4'd0, lat, bc, q, r, dz);
    checks++; if (lat !== ref_lat(4'd0)) begin errors++; $display("FAIL dz_latency got=%0d exp=%0d", lat, ref_lat(4'd0)); end
    checks++; if (q !== 4'd15 || r !== 5'd9) begin errors++; $display("FAIL dz_result got=%0d/%0d exp=15/9", q, r); end
    checks++; if (dz !== DZ_EN) begin errors++; $display("FAIL dz_flag got=%b exp=%b", dz, DZ_EN); end
    repeat (3) @(posedge clk); #1;
    checks++; if (div_zero !== DZ_EN) begin errors++; $display("FAIL dz_hold got=%b exp=%b", div_zero, DZ_EN); end
    do_op(4'd6, 4'd2, lat, bc, q, r, dz);
    checks++; if (dz !== 1'b0 || q !== 4'd3 || r !== 5'd0) begin errors++; $display("FAIL dz_clear dz=%b q=%0d r=%0d exp=0/3/0", dz, q, r); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_vectors();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_div_zero();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/nrd_seq_divider_ctrl.md
Name: nrd_seq_divider_ctrl

Overview:
- Sequential controller for the non-restoring division datapath.
- Registers the dividend and divisor on a start strobe, then runs one non-restoring add/subtract step per clock on a single shared (WIDTH+1)-bit adder/subtractor.
- Applies a final remainder restore and presents the quotient and remainder with a one-cycle done pulse.
- Replaces the combinational unrolled divider wherever the design needs area over latency.

Parameters:
WIDTH, 4, operand width in bits (X, Y, Q); the partial remainder A and the output R are WIDTH+1 bits.

Ports:
clk  input  1  system clock, rising edge active
rst_n  input  1  asynchronous active-low reset
start  input  1  request pulse; sampled only in IDLE
X  input  WIDTH  dividend, unsigned; captured when start is accepted
Y  input  WIDTH  divisor, unsigned; captured when start is accepted
busy  output  1  high while a division is in progress
done  output  1  one-cycle pulse; Q and R are valid from this cycle
Q  output  WIDTH  quotient, held until the next accepted start
R  output  WIDTH+1  remainder, held until the next accepted start; R[WIDTH] is always 0
div_zero  output  1  divide-by-zero flag (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk. rst_n is asynchronous and active-low. While rst_n=0: state=IDLE; busy, done, div_zero=0; Q=0; R=0; internal A, Qr, D and count=0.
- States: IDLE, STEP, FIX.
- IDLE:
  - start=1 at a rising edge is accepted.
  - Load A=0 (WIDTH+1 bits), Qr=X, D={1'b0,Y}, count=WIDTH.
  - Set busy=1 and go to STEP.
  - start=0: remain in IDLE.
- STEP, one iteration per cycle:
  - Shift {A,Qr} left by 1.
  - If the pre-shift A[WIDTH]=0, A = shifted A − D; otherwise A = shifted A + D.
  - Qr[0] = ~newA[WIDTH].
  - Decrement count; when count reaches 0 after this step, go to FIX.
  - Arithmetic is modulo 2^(WIDTH+1), two's complement; carry-out is discarded.
- FIX:
  - If A[WIDTH]=1, R = A + D; otherwise R = A.
  - Q = Qr; done=1 for this cycle only; busy=0; return to IDLE.
- Latency:
  - Start accepted at edge t0.
  - STEP occupies edges t1..tWIDTH.
  - done and the Q/R update become visible after edge tWIDTH+1, i.e. WIDTH+1 cycles after acceptance (5 cycles for WIDTH=4).
  - Back-to-back: start asserted in the done cycle is accepted at the next edge.
- start while busy=1: ignored; the current operation and its outputs are unaffected.
- Q and R change only in the FIX cycle (or on the div-zero path); they are otherwise stable.
- X and Y may change freely after acceptance.
- Y=0 without the optional feature: the algorithm runs the full latency and yields Q = all ones, R = {0,X}.
- Reset asserted mid-operation: immediate abort to the reset values above; no done pulse.

Optional Feature:
- Macro: NRD_DIV_ZERO_EN.
- Defined:
  - On acceptance with Y=0, skip STEP and go directly to FIX.
  - At the next edge: done=1, div_zero=1, Q = all ones, R = {0,X}.
  - div_zero holds until the next accepted start, which clears it.
- Undefined: div_zero is tied to 0 and Y=0 takes the normal WIDTH+1-cycle path with the same Q and R values.

Test Plan:
1. Reset then X=13, Y=3, start for 1 cycle -> busy high for 5 cycles; done pulses exactly once, 5 cycles after acceptance; Q=4, R=1.
2. X=7, Y=9 -> Q=0, R=7 (negative partial remainder is restored in FIX). X=15, Y=1 -> Q=15, R=0. X=0, Y=5 -> Q=0, R=0.
3. Back-to-back: start held during the done cycle with X=12, Y=4 -> second result Q=3, R=0 after 5 further cycles; first result held until then.
4. start re-pulsed at cycle 2 of a 13/3 operation with X=1, Y=1 -> ignored; result Q=4, R=1.
5. rst_n pulsed low at cycle 3 of an operation -> busy, done and Q/R go to 0 asynchronously; no done pulse; IDLE accepts a new start after release.
6. Y=0, X=9:
   - With NRD_DIV_ZERO_EN: done after 1 cycle, div_zero=1, Q=15, R=9.
   - Without it: done after 5 cycles, div_zero=0, Q=15, R=9.
